// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between a CPU load/store port and an external loader/debug port.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate contested grants; default build uses fixed CPU priority.
module mem_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 16,
    parameter int EXT_MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ext_rvalid,
    output logic              ram_rd,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int WAIT_W = (EXT_MAX_WAIT < 1) ? 1 : $clog2(EXT_MAX_WAIT + 1);

    typedef enum logic [0:0] {
        ARB       = 1'b0,
        CPU_RDATA = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_ext_q, rd_ext_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

    logic run;
    logic in_arb;
    logic cpu_req;
    logic force_ext;
    logic ext_pref;
    logic cpu_gnt;
    logic ext_gnt_w;
    logic cpu_ret;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_ext_q, last_ext_d;
`endif

    // Grant decision; every output is forced low while reset is held.
    always_comb begin
        run       = reset;
        in_arb    = (state_q == ARB);
        cpu_req   = cpu_rd | cpu_wr;
        force_ext = (wait_q == WAIT_W'(EXT_MAX_WAIT));
`ifdef MEM_ARB_ROUND_ROBIN_EN
        ext_pref  = force_ext | ~last_ext_q;
`else
        ext_pref  = force_ext;
`endif
        cpu_gnt   = run & in_arb & cpu_req & ~(ext_req & ext_pref);
        ext_gnt_w = run & ext_req & ~cpu_gnt;
        cpu_ret   = run & (state_q == CPU_RDATA) & rd_pend_q & ~rd_ext_q;
    end

    always_comb begin
        ram_rd    = 1'b0;
        ram_wr    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (cpu_gnt) begin
            ram_wr   = cpu_wr;
            ram_rd   = ~cpu_wr;
            ram_addr = cpu_addr;
            if (cpu_wr) begin
                ram_wdata = cpu_wdata;
            end
        end else if (ext_gnt_w) begin
            ram_wr   = ext_we;
            ram_rd   = ~ext_we;
            ram_addr = ext_addr;
            if (ext_we) begin
                ram_wdata = ext_wdata;
            end
        end

        ext_gnt    = ext_gnt_w;
        cpu_stall  = run & in_arb & cpu_req & (~cpu_gnt | ~cpu_wr);
        ext_rvalid = run & rd_pend_q & rd_ext_q;
        ext_rdata  = ext_rvalid ? ram_rdata : '0;

        // cpu_rdata is a holding register, transparent only in the return cycle.
        if (!run) begin
            cpu_rdata_d = '0;
        end else if (cpu_ret) begin
            cpu_rdata_d = ram_rdata;
        end else begin
            cpu_rdata_d = cpu_rdata_q;
        end
        cpu_rdata = cpu_rdata_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB:       if (cpu_gnt && !cpu_wr) state_d = CPU_RDATA;
            CPU_RDATA: state_d = ARB;
            default:   state_d = ARB;
        endcase

        rd_pend_d = (cpu_gnt & ~cpu_wr) | (ext_gnt_w & ~ext_we);
        rd_ext_d  = ext_gnt_w & ~ext_we;

        if (!ext_req || ext_gnt_w) begin
            wait_d = '0;
        end else if (!force_ext) begin
            wait_d = wait_q + WAIT_W'(1);
        end else begin
            wait_d = wait_q;
        end

`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_ext_d = last_ext_q;
        if (run && in_arb && cpu_req && ext_req) begin
            last_ext_d = ext_gnt_w;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ARB;
            wait_q      <= '0;
            rd_pend_q   <= 1'b0;
            rd_ext_q    <= 1'b0;
            cpu_rdata_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_ext_q  <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            rd_pend_q   <= rd_pend_d;
            rd_ext_q    <= rd_ext_d;
            cpu_rdata_q <= cpu_rdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_ext_q  <= last_ext_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by protocol-legal random traffic
// checked cycle by cycle against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int AW   = 12;
    localparam int DW   = 16;
    localparam int MAXW = 8;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          cpu_rd, cpu_wr;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          cpu_stall;
    logic          ext_req, ext_we, ext_gnt, ext_rvalid;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata, ext_rdata;
    logic          ram_rd, ram_wr;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .EXT_MAX_WAIT(MAXW)) dut (
        .clk(clk), .reset(reset),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
        .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM with a bench-side preload port.
    logic [DW-1:0] mem [0:4095];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (ram_wr) mem[ram_addr] <= ram_wdata;
        if (ram_rd) ram_rdata <= mem[ram_addr];
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: shadow memory plus transaction bookkeeping.
    logic [DW-1:0] mm [0:4095];
    int            m_wait;
    bit            m_cpu_ret, m_ext_ret, m_last_ext;
    logic [DW-1:0] m_cpu_due, m_ext_due, m_cpu_held;
    bit            g_cpu, g_ext;
    bit            exp_stall, exp_gnt;

    task automatic model_reset();
        m_wait     = 0;
        m_cpu_ret  = 1'b0;
        m_ext_ret  = 1'b0;
        m_last_ext = 1'b1;
        m_cpu_held = '0;
        m_cpu_due  = '0;
        m_ext_due  = '0;
    endtask

    task automatic eval();
        bit            creq, ext_first;
        bit            e_rd, e_wr, e_stall, e_rv;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd, e_rdx, e_crd;
        @(negedge clk);
        g_cpu = 0; g_ext = 0; e_rd = 0; e_wr = 0; e_stall = 0; e_rv = 0;
        e_addr = '0; e_wd = '0; e_rdx = '0; e_crd = '0;
        if (reset) begin
            creq = cpu_rd | cpu_wr;
            if (m_cpu_ret) begin
                g_ext = ext_req;
            end else if (creq && ext_req) begin
                ext_first = (m_wait >= MAXW) || (RR && !m_last_ext);
                g_ext = ext_first;
                g_cpu = !ext_first;
            end else begin
                g_cpu = creq;
                g_ext = ext_req;
            end
            if (g_cpu) begin
                e_wr = cpu_wr; e_rd = !cpu_wr; e_addr = cpu_addr;
                if (cpu_wr) e_wd = cpu_wdata;
            end else if (g_ext) begin
                e_wr = ext_we; e_rd = !ext_we; e_addr = ext_addr;
                if (ext_we) e_wd = ext_wdata;
            end
            e_stall = !m_cpu_ret && creq && !(g_cpu && cpu_wr);
            e_rv    = m_ext_ret;
            e_rdx   = m_ext_ret ? m_ext_due : '0;
            e_crd   = m_cpu_ret ? m_cpu_due : m_cpu_held;
        end
        exp_stall = e_stall;
        exp_gnt   = g_ext;
        chk("ram_rd", 32'(ram_rd), 32'(e_rd));
        chk("ram_wr", 32'(ram_wr), 32'(e_wr));
        chk("ram_addr", 32'(ram_addr), 32'(e_addr));
        if (!e_rd) chk("ram_wdata", 32'(ram_wdata), 32'(e_wd));
        chk("cpu_stall", 32'(cpu_stall), 32'(e_stall));
        chk("cpu_rdata", 32'(cpu_rdata), 32'(e_crd));
        chk("ext_gnt", 32'(ext_gnt), 32'(g_ext));
        chk("ext_rvalid", 32'(ext_rvalid), 32'(e_rv));
        chk("ext_rdata", 32'(ext_rdata), 32'(e_rdx));
    endtask

    task automatic commit();
        bit            contested;
        bit            n_cpu_ret, n_ext_ret;
        logic [DW-1:0] n_cpu_due, n_ext_due;
        if (!reset) begin
            model_reset();
        end else begin
            contested = (cpu_rd | cpu_wr) && ext_req && !m_cpu_ret;
            if (m_cpu_ret) m_cpu_held = m_cpu_due;
            n_cpu_ret = g_cpu && !cpu_wr;
            n_cpu_due = mm[cpu_addr];
            n_ext_ret = g_ext && !ext_we;
            n_ext_due = mm[ext_addr];
            if (g_cpu && cpu_wr) mm[cpu_addr] = cpu_wdata;
            if (g_ext && ext_we) mm[ext_addr] = ext_wdata;
            if (RR && contested) m_last_ext = g_ext;
            if (ext_req && !g_ext) m_wait = (m_wait < MAXW) ? m_wait + 1 : MAXW;
            else m_wait = 0;
            m_cpu_ret = n_cpu_ret; m_cpu_due = n_cpu_due;
            m_ext_ret = n_ext_ret; m_ext_due = n_ext_due;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        eval();
        commit();
    endtask

    task automatic idle();
        cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
        ext_req = 0; ext_we = 0; ext_addr = '0; ext_wdata = '0;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_en = 1; pl_addr = a; pl_data = d;
        mm[a] = d;
        step();
    endtask

    logic [DW-1:0] v12;
    bit            cpu_hold, ext_hold;
    int unsigned   op;

    initial begin
        reset = 0; pl_en = 0; pl_addr = '0; pl_data = '0;
        idle();
        model_reset();
        @(posedge clk);
        #1;

        // Reset held with random requests present: all outputs must stay zero.
        for (int unsigned i = 0; i < 32; i++) begin
            cpu_rd = 1'($urandom); cpu_wr = 1'($urandom); cpu_addr = 12'($urandom);
            ext_req = 1'($urandom); ext_we = 1'($urandom); ext_addr = 12'($urandom);
            preload(12'(i), 16'($urandom));
        end
        idle();
        preload(12'h010, 16'hBEEF);
        preload(12'h200, 16'h5A5A);
        preload(12'h0A5, 16'h0000);
        pl_en = 0;
        v12 = mm[12'h012];
        reset = 1;
        step();

        // CPU store completes in the same cycle.
        cpu_wr = 1; cpu_addr = 12'h0A5; cpu_wdata = 16'h1234;
        eval();
        chk("st_ram_wr", 32'(ram_wr), 32'd1);
        chk("st_ram_addr", 32'(ram_addr), 32'h0A5);
        chk("st_ram_wdata", 32'(ram_wdata), 32'h1234);
        chk("st_stall", 32'(cpu_stall), 32'd0);
        commit();
        idle();

        // CPU load: stall in the issue cycle, data in the following one.
        cpu_rd = 1; cpu_addr = 12'h010;
        eval();
        chk("ld_ram_rd", 32'(ram_rd), 32'd1);
        chk("ld_stall0", 32'(cpu_stall), 32'd1);
        commit();
        eval();
        chk("ld_rdata", 32'(cpu_rdata), 32'hBEEF);
        chk("ld_stall1", 32'(cpu_stall), 32'd0);
        commit();
        idle();
        step();

        // External read returns one cycle after its grant.
        ext_req = 1; ext_addr = 12'h200;
        eval();
        chk("ext_gnt", 32'(ext_gnt), 32'd1);
        commit();
        idle();
        eval();
        chk("ext_rvalid", 32'(ext_rvalid), 32'd1);
        chk("ext_rdata", 32'(ext_rdata), 32'h5A5A);
        commit();

        // External read immediately followed by a CPU read.
        ext_req = 1; ext_addr = 12'h011;
        step();
        idle();
        cpu_rd = 1; cpu_addr = 12'h012;
        eval();
        chk("b2b_ext_rvalid", 32'(ext_rvalid), 32'd1);
        chk("b2b_cpu_hold", 32'(cpu_rdata), 32'hBEEF);
        commit();
        eval();
        chk("b2b_cpu_rdata", 32'(cpu_rdata), 32'(v12));
        chk("b2b_ext_quiet", 32'(ext_rvalid), 32'd0);
        commit();
        idle();
        step();

`ifndef MEM_ARB_ROUND_ROBIN_EN
        // Starvation guard: CPU stores every cycle, external wins on the ninth.
        ext_req = 1; ext_we = 1; ext_addr = 12'h005; ext_wdata = 16'hC0DE;
        for (int unsigned k = 1; k <= 9; k++) begin
            cpu_wr = 1; cpu_addr = 12'(k); cpu_wdata = 16'(k * 3);
            eval();
            chk("starve_gnt", 32'(ext_gnt), 32'(k == 9));
            if (k == 9) chk("starve_stall", 32'(cpu_stall), 32'd1);
            commit();
        end
        ext_req = 0;
        step();
`else
        // Continuous contention alternates CPU, EXT, CPU, ...
        cpu_wr = 1; cpu_addr = 12'h003; cpu_wdata = 16'h1000;
        ext_req = 1; ext_we = 1; ext_addr = 12'h004; ext_wdata = 16'h2000;
        for (int unsigned k = 0; k < 8; k++) begin
            eval();
            chk("rr_ext_gnt", 32'(ext_gnt), 32'(k % 2));
            chk("rr_cpu_stall", 32'(cpu_stall), 32'(k % 2));
            commit();
            if (k % 2 == 0) cpu_wdata = cpu_wdata + 16'd1;
            else ext_wdata = ext_wdata + 16'd1;
        end
`endif
        idle();
        step();

        // Reset right after an external read grant suppresses the return.
        ext_req = 1; ext_addr = 12'h200;
        eval();
        chk("rst_ext_gnt", 32'(ext_gnt), 32'd1);
        commit();
        idle();
        reset = 0; cpu_rd = 1; cpu_addr = 12'h010;
        eval();
        chk("rst_rvalid", 32'(ext_rvalid), 32'd0);
        chk("rst_ram_rd", 32'(ram_rd), 32'd0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        commit();
        reset = 1; cpu_rd = 0;
        eval();
        chk("rst_after_rvalid", 32'(ext_rvalid), 32'd0);
        commit();

        // Random protocol-legal traffic with occasional resets.
        cpu_hold = 0; ext_hold = 0;
        for (int unsigned c = 0; c < 3000; c++) begin
            reset = ($urandom_range(99) != 0);
            if (!cpu_hold) begin
                op = $urandom_range(3);
                cpu_rd = (op == 1) || (op == 3);
                cpu_wr = (op >= 2);
                cpu_addr = 12'($urandom_range(31));
                cpu_wdata = 16'($urandom);
            end
            if (!ext_hold) begin
                ext_req = 1'($urandom);
                ext_we = 1'($urandom);
                ext_addr = 12'($urandom_range(31));
                ext_wdata = 16'($urandom);
            end
            eval();
            cpu_hold = exp_stall;
            ext_hold = ext_req && !exp_gnt;
            commit();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
